// File: rtl/periferico_irq_if.sv
// rtl/periferico_irq_if.sv - CPU port/interrupt bundle between the CPU and periferico_irq
interface periferico_irq_if;
    logic [7:0] ev_data;
    logic       ev_valid;
    logic [7:0] s;
    logic [7:0] s1;
    logic [7:0] e;
    logic [7:0] e1;
    logic       interrupcion;

    modport master (
        output ev_data, ev_valid, s, s1,
        input  e, e1, interrupcion
    );

    modport slave (
        input  ev_data, ev_valid, s, s1,
        output e, e1, interrupcion
    );
endinterface

// File: rtl/periferico_irq.sv
// rtl/periferico_irq.sv - 4-entry event FIFO plus periodic timer, level interrupt, toggle-strobe commands
module periferico_irq #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    periferico_irq_if.slave  bus
);
    localparam logic [1:0] CMD_POP  = 2'b00;
    localparam logic [1:0] CMD_CLR  = 2'b01;
    localparam logic [1:0] CMD_LOAD = 2'b10;
    localparam logic [1:0] CMD_ACKT = 2'b11;
    localparam logic [2:0] FULL_CNT = 3'(DEPTH);

    logic       tog_q, tog_d;
    logic [1:0] rd_q, rd_d, wr_q, wr_d;
    logic [2:0] count_q, count_d;
    logic       ovf_q, ovf_d;
    logic       tflag_q, tflag_d;
    logic [7:0] reload_q, reload_d;
    logic [7:0] tcnt_q, tcnt_d;
    logic [7:0] mem_q [DEPTH];

    logic strobe, pop_cmd, clr_cmd, load_cmd, ackt_cmd;
    logic empty, full, do_pop, do_push, expire;
    logic unused_bits;

    assign unused_bits = ^bus.s[6:2];

    assign strobe   = bus.s[7] ^ tog_q;
    assign pop_cmd  = strobe && (bus.s[1:0] == CMD_POP);
    assign clr_cmd  = strobe && (bus.s[1:0] == CMD_CLR);
    assign load_cmd = strobe && (bus.s[1:0] == CMD_LOAD);
    assign ackt_cmd = strobe && (bus.s[1:0] == CMD_ACKT);

    assign empty   = (count_q == 3'd0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop_cmd && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
    assign do_push = bus.ev_valid && (!full || do_pop) && !clr_cmd;
    assign expire  = (reload_q != 8'd0) && (tcnt_q == 8'd1) && !load_cmd;

    always_comb begin
        tog_d    = bus.s[7];
        rd_d     = rd_q;
        wr_d     = wr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        tflag_d  = tflag_q;
        reload_d = reload_q;
        tcnt_d   = tcnt_q;

        if (clr_cmd) begin
            rd_d    = 2'd0;
            wr_d    = 2'd0;
            count_d = 3'd0;
            ovf_d   = 1'b0;
        end else begin
            if (do_push) wr_d = wr_q + 2'd1;
            if (do_pop)  rd_d = rd_q + 2'd1;
            if (do_push && !do_pop)      count_d = count_q + 3'd1;
            else if (do_pop && !do_push) count_d = count_q - 3'd1;
            if (bus.ev_valid && full && !do_pop) ovf_d = 1'b1;
        end

        if (load_cmd) begin
            reload_d = bus.s1;
            tcnt_d   = bus.s1;
        end else if (reload_q != 8'd0) begin
            tcnt_d = (tcnt_q == 8'd1) ? reload_q : tcnt_q - 8'd1;
        end

        // Expiry beats a simultaneous acknowledge
        if (expire)        tflag_d = 1'b1;
        else if (ackt_cmd) tflag_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tog_q    <= 1'b0;
            rd_q     <= 2'd0;
            wr_q     <= 2'd0;
            count_q  <= 3'd0;
            ovf_q    <= 1'b0;
            tflag_q  <= 1'b0;
            reload_q <= 8'd0;
            tcnt_q   <= 8'd0;
        end else begin
            tog_q    <= tog_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            tflag_q  <= tflag_d;
            reload_q <= reload_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !reset) mem_q[wr_q] <= bus.ev_data;
    end

    assign bus.e            = empty ? 8'h00 : mem_q[rd_q];
    assign bus.e1           = {1'b0, full, empty, tflag_q, ovf_q, count_q};
    assign bus.interrupcion = !empty || tflag_q;
endmodule

// File: tb/tb_periferico_irq.sv
// tb/tb_periferico_irq.sv - directed self-checking bench for periferico_irq
module tb_periferico_irq;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    periferico_irq_if bus();

    periferico_irq #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [1:0] c, input logic [7:0] op);
        bus.s  = {~bus.s[7], 5'b00000, c};
        bus.s1 = op;
        tick();
    endtask

    task automatic push(input logic [7:0] d);
        bus.ev_data  = d;
        bus.ev_valid = 1'b1;
        tick();
        bus.ev_valid = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        bus.ev_data  = 8'h00;
        bus.ev_valid = 1'b0;
        bus.s        = 8'h00;
        bus.s1       = 8'h00;
        tick();
        tick();
        reset = 1'b0;
        check("reset_e", bus.e, 8'h00);
        check("reset_e1", bus.e1, 8'h20);
        check("reset_irq", {7'd0, bus.interrupcion}, 8'h01 & 8'h00);

        bus.ev_valid = 1'b1;
        bus.ev_data  = 8'h11;
        tick();
        check("push1_irq", {7'd0, bus.interrupcion}, 8'h01);
        check("push1_e", bus.e, 8'h11);
        bus.ev_data = 8'h22;
        tick();
        bus.ev_data = 8'h33;
        tick();
        bus.ev_valid = 1'b0;
        check("push3_e", bus.e, 8'h11);
        check("push3_e1", bus.e1, 8'h03);
        cmd(2'b00, 8'h00);
        check("pop1_e", bus.e, 8'h22);
        cmd(2'b00, 8'h00);
        check("pop2_e", bus.e, 8'h33);
        cmd(2'b00, 8'h00);
        check("pop3_e", bus.e, 8'h00);
        check("pop3_e1", bus.e1, 8'h20);
        check("pop3_irq", {7'd0, bus.interrupcion}, 8'h00);

        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
        check("fill_e1", bus.e1, 8'h44);
        check("fill_e", bus.e, 8'hA0);
        push(8'hA4);
        check("ovf_e1", bus.e1, 8'h4C);
        check("ovf_e", bus.e, 8'hA0);
        bus.ev_data  = 8'hA5;
        bus.ev_valid = 1'b1;
        cmd(2'b00, 8'h00);
        bus.ev_valid = 1'b0;
        check("pushpop_full_e", bus.e, 8'hA1);
        check("pushpop_full_e1", bus.e1, 8'h4C);
        cmd(2'b01, 8'h00);
        check("clr_e1", bus.e1, 8'h20);
        check("clr_e", bus.e, 8'h00);

        push(8'h77);
        push(8'h88);
        check("pre_rst_e1", bus.e1, 8'h02);
        bus.s = 8'h00;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_e", bus.e, 8'h00);
        check("midrst_e1", bus.e1, 8'h20);
        check("midrst_irq", {7'd0, bus.interrupcion}, 8'h00);

        cmd(2'b10, 8'd5);                           // edge N
        check("load_flag", bus.e1, 8'h20);
        for (int i = 0; i < 3; i++) tick();         // N+4 after next tick
        tick();
        check("n4_e1", bus.e1, 8'h20);
        check("n4_irq", {7'd0, bus.interrupcion}, 8'h00);
        tick();                                     // N+5
        check("n5_e1", bus.e1, 8'h30);
        check("n5_irq", {7'd0, bus.interrupcion}, 8'h01);
        tick();                                     // N+6
        cmd(2'b11, 8'h00);                          // ACKT at N+7
        check("ackt_e1", bus.e1, 8'h20);
        check("ackt_irq", {7'd0, bus.interrupcion}, 8'h00);
        tick();                                     // N+8
        tick();                                     // N+9
        check("n9_e1", bus.e1, 8'h20);
        tick();                                     // N+10
        check("n10_e1", bus.e1, 8'h30);
        cmd(2'b11, 8'h00);                          // N+11 clears
        check("n11_e1", bus.e1, 8'h20);
        for (int i = 0; i < 3; i++) tick();         // N+14
        check("n14_e1", bus.e1, 8'h20);
        cmd(2'b11, 8'h00);                          // ACKT coincides with expiry at N+15
        check("ackt_vs_exp_e1", bus.e1, 8'h30);
        cmd(2'b11, 8'h00);                          // N+16
        check("late_ackt_e1", bus.e1, 8'h20);

        cmd(2'b10, 8'd0);
        for (int i = 0; i < 20; i++) tick();
        check("timer_off_e1", bus.e1, 8'h20);
        check("timer_off_irq", {7'd0, bus.interrupcion}, 8'h00);

        bus.ev_data  = 8'h55;
        bus.ev_valid = 1'b1;
        cmd(2'b01, 8'h00);
        bus.ev_valid = 1'b0;
        check("clr_push_e1", bus.e1, 8'h20);
        check("clr_push_e", bus.e, 8'h00);

        cmd(2'b00, 8'h00);
        check("pop_empty_e1", bus.e1, 8'h20);
        check("pop_empty_e", bus.e, 8'h00);
        check("pop_empty_irq", {7'd0, bus.interrupcion}, 8'h00);

        push(8'h66);
        push(8'h99);
        bus.ev_data  = 8'hBB;
        bus.ev_valid = 1'b1;
        cmd(2'b00, 8'h00);
        bus.ev_valid = 1'b0;
        check("pushpop_mid_e", bus.e, 8'h99);
        check("pushpop_mid_e1", bus.e1, 8'h02);
        cmd(2'b00, 8'h00);
        check("pushpop_tail_e", bus.e, 8'hBB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
